prange: RTL

PRANGE -- requirements
Module: prange

---
 rtl/prange_if.sv | 27 ++
 rtl/prange.sv | 115 +++++++++++
 2 files changed

// File: rtl/prange_if.sv
// Handshake and data bundle for the prange sequence generator.
// master: the side that issues _start/base/limit/step and drives _ready.
// slave:  the generator itself, which presents _valid/_done/_out/_index.
interface prange_if #(
    parameter int WIDTH = 32,
    parameter int NOUT  = 2
);
    logic                           _start;
    logic signed [WIDTH-1:0]        base;
    logic signed [WIDTH-1:0]        limit;
    logic signed [WIDTH-1:0]        step;
    logic                           _ready;
    logic                           _valid;
    logic                           _done;
    logic signed [NOUT*WIDTH-1:0]   _out;
    logic        [WIDTH-1:0]        _index;

    modport master (
        output _start, base, limit, step, _ready,
        input  _valid, _done, _out, _index
    );

    modport slave (
        input  _start, base, limit, step, _ready,
        output _valid, _done, _out, _index
    );
endinterface

// File: rtl/prange.sv
// prange: streams base, base+step, ... while the value stays short of the
// exclusive limit, duplicated across NOUT output lanes with a ready/valid
// handshake. Arithmetic is done in WIDTH+1 bits so an overflowing step ends
// the sequence instead of wrapping.
// Optional feature macro: PRANGE_NEG_STEP_EN (descending sequences for
// negative step; otherwise step <= 0 yields an empty sequence).
module prange #(
    parameter int WIDTH = 32,
    parameter int NOUT  = 2
) (
    input  logic     _clock,
    input  logic     _reset,
    prange_if.slave  bus
);
    typedef enum logic {
        S_DONE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic signed [WIDTH-1:0] i_reg, i_next;
    logic signed [WIDTH-1:0] limit_reg, limit_next;
    logic signed [WIDTH-1:0] step_reg, step_next;
    logic        [WIDTH-1:0] index_reg, index_next;
    logic                    done_reg, done_next;
    logic signed [WIDTH:0]   sum_ext;

    // Sign-extend a WIDTH value to WIDTH+1 bits.
    function automatic logic signed [WIDTH:0] ext(input logic signed [WIDTH-1:0] x);
        return {x[WIDTH-1], x};
    endfunction

    // True when v is representable in WIDTH bits and lies on the near side
    // of the limit for the direction of travel given by the step sign.
    function automatic logic keep_going(input logic signed [WIDTH:0] v,
                                        input logic signed [WIDTH:0] lim,
                                        input logic signed [WIDTH:0] stp);
        logic ok;
        logic fits;
        fits = (v[WIDTH] == v[WIDTH-1]);
        ok   = 1'b0;
        if (!stp[WIDTH] && (stp != '0)) begin
            ok = (v < lim);
        end
`ifdef PRANGE_NEG_STEP_EN
        else if (stp[WIDTH]) begin
            ok = (v > lim);
        end
`else
`endif
        return ok && fits;
    endfunction

    // State and datapath registers; reset drops everything to idle/zero at once.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_reg <= S_DONE;
            i_reg     <= '0;
            limit_reg <= '0;
            step_reg  <= '0;
            index_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            limit_reg <= limit_next;
            step_reg  <= step_next;
            index_reg <= index_next;
            done_reg  <= done_next;
        end
    end

    // Next state: _start always wins; otherwise advance on each transfer.
    always_comb begin
        sum_ext    = ext(i_reg) + ext(step_reg);
        state_next = state_reg;
        i_next     = i_reg;
        limit_next = limit_reg;
        step_next  = step_reg;
        index_next = index_reg;
        done_next  = 1'b0;
        if (bus._start) begin
            i_next     = bus.base;
            limit_next = bus.limit;
            step_next  = bus.step;
            index_next = '0;
            state_next = keep_going(ext(bus.base), ext(bus.limit), ext(bus.step))
                         ? S_RUN : S_DONE;
        end else begin
            // _done trails entry into S_DONE by one cycle.
            done_next = (state_reg == S_DONE);
            if ((state_reg == S_RUN) && bus._ready) begin
                if (keep_going(sum_ext, ext(limit_reg), ext(step_reg))) begin
                    i_next     = sum_ext[WIDTH-1:0];
                    index_next = index_reg + WIDTH'(1);
                end else begin
                    state_next = S_DONE;
                end
            end
        end
    end

    // Outputs: an element is presented exactly while in S_RUN.
    always_comb begin
        bus._valid = (state_reg == S_RUN);
        bus._done  = done_reg;
        bus._index = index_reg;
    end

    generate
        for (genvar gi = 0; gi < NOUT; gi++) begin : g_lane
            assign bus._out[gi*WIDTH +: WIDTH] = i_reg;
        end
    endgenerate
endmodule
